data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port data RAM behind a fixed-latency request FSM.
//
// A MEM-stage read or write request is latched in IDLE and held in BUSY for
// WAIT_CYCLES+1 cycles. The RAM access happens on the last BUSY edge. The
// block then spends one DONE cycle with mem_stall low so the pipeline can
// advance. Load data is registered and holds until the next completed read.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// (mem_addr[1:0] != 0). Such accesses keep the normal timing, but the write
// is dropped, a read returns 0, and mem_err is raised in the DONE cycle.
// Without the macro, mem_addr[1:0] is ignored and mem_err is tied low.
//
// Handshake: mem_ren/mem_wen act as a level-sensitive valid that the
// pipeline holds stable while mem_stall is high. mem_stall is the inverse of
// ready. A request completes in the cycle where mem_stall drops (DONE).
// Dropping both request lines during BUSY is a flush and aborts the access.

module data_mem_resp #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        mem_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [31:0]             wdata_q;
   logic                    is_wr_q;
   logic                    misal_q;

   logic                    req;
   logic                    misal_in;
   logic                    stall_c;
   logic                    access;
   logic                    latch_req;
   logic                    ram_we;
   logic                    ram_re;

   logic [31:0]             ram [0:DEPTH-1];

   // Address bits outside the word index only matter for the alignment check.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

   assign req = mem_ren | mem_wen;

`ifdef DMEM_ALIGN_CHECK_EN
   assign misal_in = (mem_addr[1:0] != 2'b00);
`else
   assign misal_in = 1'b0;
`endif

   // Next-state, counter and stall decode for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_c   = 1'b0;
      access    = 1'b0;
      latch_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               stall_c   = 1'b1;
               latch_req = 1'b1;
               cnt_d     = WAIT_INIT;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (!req) begin
               // Flush: abandon the access without touching RAM or mem_din.
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Stall is forced low while reset is held, even with a request present.
   assign mem_stall = rst_n & stall_c;
   assign dbg_state = state_q;

   // A write wins when both request lines are high.
   assign ram_we = access & is_wr_q & ~misal_q;
   assign ram_re = access & ~is_wr_q;

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture: inputs are sampled only when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         wdata_q <= 32'd0;
         is_wr_q <= 1'b0;
         misal_q <= 1'b0;
      end else if (latch_req) begin
         idx_q   <= mem_addr[ADDR_WIDTH+1:2];
         wdata_q <= mem_dout;
         is_wr_q <= mem_wen;
         misal_q <= misal_in;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[idx_q] <= wdata_q;
      end
   end

   // Registered load data; a misaligned read returns zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_din <= 32'd0;
      end else if (ram_re) begin
         mem_din <= misal_q ? 32'd0 : ram[idx_q];
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   // Error flag is high only in the DONE cycle of a misaligned access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err <= 1'b0;
      end else begin
         mem_err <= access & misal_q;
      end
   end
`else
   assign mem_err = 1'b0;
`endif

endmodule
